// File: rtl/wb_stream_writer_cfg_mc.sv
// Wishbone config/status block for NCH stream-writer channels: per-channel address/size/burst,
// start/auto-restart control, completion counters, sticky IRQ status. Option: WB_STREAM_CFG_ERR_EN.
module wb_stream_writer_cfg_mc #(
    parameter int NCH   = 1,
    parameter int WB_AW = 32,
    parameter int WB_DW = 32,
    parameter int CNT_W = 16
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    input  logic [7:0]           wb_adr_i,
    input  logic [WB_DW-1:0]     wb_dat_i,
    input  logic [WB_DW/8-1:0]   wb_sel_i,
    input  logic                 wb_we_i,
    input  logic                 wb_cyc_i,
    input  logic                 wb_stb_i,
    input  logic [2:0]           wb_cti_i,
    input  logic [1:0]           wb_bte_i,
    output logic [WB_DW-1:0]     wb_dat_o,
    output logic                 wb_ack_o,
    output logic                 wb_err_o,
    output logic                 wb_rty_o,
    output logic                 irq,
    input  logic [NCH-1:0]       busy,
    output logic [NCH-1:0]       enable,
    input  logic [NCH*WB_DW-1:0] tx_cnt,
    output logic [NCH*WB_AW-1:0] start_adr,
    output logic [NCH*WB_AW-1:0] buf_size,
    output logic [NCH*WB_AW-1:0] burst_size
);

    logic                r_resp;
    logic [NCH-1:0]      r_busy;
    logic [NCH-1:0]      r_enable;
    logic [NCH-1:0]      r_cont;
    logic [NCH-1:0]      r_irq_status;
    logic [NCH-1:0]      r_irq_mask;
    logic [WB_AW-1:0]    r_start_adr  [NCH];
    logic [WB_AW-1:0]    r_buf_size   [NCH];
    logic [WB_AW-1:0]    r_burst_size [NCH];
    logic [CNT_W-1:0]    r_done_cnt   [NCH];

    logic [2:0]          w_bank;
    logic [2:0]          w_reg;
    logic                w_is_glb;
    logic [NCH-1:0]      w_chsel;
    logic                w_mapped;
    logic                w_bad;
    logic                w_wr;
    logic [NCH-1:0]      w_ctrl_wr;
    logic [NCH-1:0]      w_start;
    logic [NCH-1:0]      w_fall;
    logic [NCH-1:0]      w_w1c;
    logic [WB_DW-1:0]    w_rd;
    logic                w_unused;

    assign w_bank   = wb_adr_i[7:5];
    assign w_reg    = wb_adr_i[4:2];
    assign w_is_glb = (w_bank == 3'd0);

    always_comb begin
        w_chsel = '0;
        for (int unsigned c = 0; c < NCH; c++)
            w_chsel[c] = (w_bank == 3'(c + 1));
    end

    assign w_mapped = (w_is_glb | (|w_chsel)) & (w_reg < 3'd6);

`ifdef WB_STREAM_CFG_ERR_EN
    logic w_start_busy;
    assign w_start_busy = wb_we_i & (w_reg == 3'd0) & wb_dat_i[0] & (|(w_chsel & busy));
    assign w_bad        = ~w_mapped | w_start_busy;
`else
    assign w_bad        = 1'b0;
`endif

    // Response decision is taken in the response cycle, the same cycle the write commits.
    assign wb_ack_o = r_resp & ~w_bad;
    assign wb_err_o = r_resp & w_bad;
    assign wb_rty_o = 1'b0;

    assign w_wr   = r_resp & wb_we_i & ~w_bad & w_mapped;
    assign w_fall = ~busy & r_busy;
    assign w_w1c  = (w_wr & w_is_glb & (w_reg == 3'd0)) ? wb_dat_i[NCH-1:0] : '0;

    always_comb begin
        w_ctrl_wr = '0;
        w_start   = '0;
        for (int unsigned c = 0; c < NCH; c++) begin
            w_ctrl_wr[c] = w_wr & w_chsel[c] & (w_reg == 3'd0);
            w_start[c]   = w_ctrl_wr[c] & wb_dat_i[0] & ~busy[c];
        end
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_resp       <= 1'b0;
            r_busy       <= '0;
            r_enable     <= '0;
            r_cont       <= '0;
            r_irq_status <= '0;
            r_irq_mask   <= '0;
            for (int unsigned c = 0; c < NCH; c++) begin
                r_start_adr[c]  <= '0;
                r_buf_size[c]   <= '0;
                r_burst_size[c] <= '0;
                r_done_cnt[c]   <= '0;
            end
        end else begin
            r_resp   <= wb_cyc_i & wb_stb_i & ~r_resp;
            r_busy   <= busy;
            // Manual start and auto-restart merge into one pulse.
            r_enable <= w_start | (w_fall & r_cont);
            r_irq_status <= (r_irq_status & ~w_w1c) | w_fall;
            if (w_wr & w_is_glb & (w_reg == 3'd1))
                r_irq_mask <= wb_dat_i[NCH-1:0];
            for (int unsigned c = 0; c < NCH; c++) begin
                if (w_ctrl_wr[c])
                    r_cont[c] <= wb_dat_i[1];
                if (w_wr & w_chsel[c] & (w_reg == 3'd1))
                    r_start_adr[c] <= WB_AW'(wb_dat_i);
                if (w_wr & w_chsel[c] & (w_reg == 3'd2))
                    r_buf_size[c] <= WB_AW'(wb_dat_i);
                if (w_wr & w_chsel[c] & (w_reg == 3'd3))
                    r_burst_size[c] <= WB_AW'(wb_dat_i);
                if (w_fall[c])
                    r_done_cnt[c] <= r_done_cnt[c] + 1'b1;
            end
        end
    end

    always_comb begin
        w_rd = '0;
        if (w_is_glb) begin
            case (w_reg)
                3'd0:    w_rd = WB_DW'(r_irq_status);
                3'd1:    w_rd = WB_DW'(r_irq_mask);
                3'd2:    w_rd = WB_DW'(8'(NCH));
                default: w_rd = '0;
            endcase
        end
        for (int unsigned c = 0; c < NCH; c++) begin
            if (w_chsel[c]) begin
                case (w_reg)
                    3'd0:    w_rd = WB_DW'({r_cont[c], busy[c]});
                    3'd1:    w_rd = WB_DW'(r_start_adr[c]);
                    3'd2:    w_rd = WB_DW'(r_buf_size[c]);
                    3'd3:    w_rd = WB_DW'(r_burst_size[c]);
                    3'd4:    w_rd = tx_cnt[c*WB_DW +: WB_DW] << 2;
                    3'd5:    w_rd = WB_DW'(r_done_cnt[c]);
                    default: w_rd = '0;
                endcase
            end
        end
    end

    assign wb_dat_o = w_mapped ? w_rd : '0;
    assign irq      = |(r_irq_status & r_irq_mask);
    assign enable   = r_enable;

    for (genvar g = 0; g < NCH; g++) begin : g_pack
        assign start_adr [g*WB_AW +: WB_AW] = r_start_adr[g];
        assign buf_size  [g*WB_AW +: WB_AW] = r_buf_size[g];
        assign burst_size[g*WB_AW +: WB_AW] = r_burst_size[g];
    end

    assign w_unused = ^{wb_sel_i, wb_cti_i, wb_bte_i, wb_adr_i[1:0]};

endmodule

// File: tb/tb_wb_stream_writer_cfg_mc.sv
// Directed bench for wb_stream_writer_cfg_mc with NCH=3; expectations follow WB_STREAM_CFG_ERR_EN if defined.
module tb_wb_stream_writer_cfg_mc;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [3:0]  sel_i = 4'hF;
    logic        we_i = 1'b0;
    logic        cyc = 1'b0;
    logic        stb = 1'b0;
    logic [2:0]  cti = '0;
    logic [1:0]  bte = '0;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o, wb_err_o, wb_rty_o, irq;
    logic [2:0]  busy = '0;
    logic [2:0]  enable;
    logic [95:0] tx_cnt = '0;
    logic [95:0] start_adr, buf_size, burst_size;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    wb_stream_writer_cfg_mc #(.NCH(3), .WB_AW(32), .WB_DW(32), .CNT_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .wb_adr_i(adr_i), .wb_dat_i(dat_i), .wb_sel_i(sel_i),
        .wb_we_i(we_i), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_cti_i(cti), .wb_bte_i(bte),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .irq(irq), .busy(busy), .enable(enable), .tx_cnt(tx_cnt),
        .start_adr(start_adr), .buf_size(buf_size), .burst_size(burst_size)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic bus(input logic [7:0] adr, input logic we, input logic [31:0] dat,
                       output logic [31:0] rdat, output logic ack, output logic err);
        int unsigned n = 0;
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_i = we; adr_i = adr; dat_i = dat;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!(wb_ack_o | wb_err_o) && n < 8);
        if (!(wb_ack_o | wb_err_o)) check("bus_timeout", 32'd0, 32'd1);
        ack = wb_ack_o; err = wb_err_o; rdat = wb_dat_o;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
    endtask

    task automatic rd(input logic [7:0] adr, input logic [31:0] exp, input string tag);
        logic [31:0] d;
        logic a, e;
        bus(adr, 1'b0, 32'd0, d, a, e);
        check(tag, d, exp);
    endtask

    task automatic wr(input logic [7:0] adr, input logic [31:0] dat);
        logic [31:0] d;
        logic a, e;
        bus(adr, 1'b1, dat, d, a, e);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic a, e;

        repeat (3) @(posedge clk);
        #1;
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_enable", {29'd0, enable}, 32'd0);
        check("rst_ack", {31'd0, wb_ack_o}, 32'd0);
        rst = 1'b0;

        rd(8'h08, 32'h3, "info");
        rd(8'h00, 32'h0, "rst_status");
        rd(8'h04, 32'h0, "rst_mask");
        for (int b = 1; b <= 3; b++)
            for (int r = 0; r <= 5; r++)
                rd(8'((b << 5) | (r << 2)), 32'h0, $sformatf("rst_b%0d_r%0d", b, r));

        // Channel 1 configuration
        wr(8'h44, 32'h1000);
        wr(8'h48, 32'h400);
        wr(8'h4C, 32'h10);
        rd(8'h44, 32'h1000, "ch1_start_adr");
        rd(8'h48, 32'h400, "ch1_buf_size");
        rd(8'h4C, 32'h10, "ch1_burst_size");
        check("start_adr_port_ch1", start_adr[63:32], 32'h1000);
        check("start_adr_port_ch0", start_adr[31:0], 32'h0);
        check("buf_size_port_ch1", buf_size[63:32], 32'h400);
        check("burst_size_port_ch1", burst_size[63:32], 32'h10);

        // tx_cnt scaled to bytes, truncated
        tx_cnt[31:0]  = 32'h4000_0005;
        tx_cnt[95:64] = 32'h0000_0100;
        rd(8'h30, 32'h14, "ch0_txcnt_trunc");
        rd(8'h70, 32'h400, "ch2_txcnt");
        tx_cnt = '0;

        // Manual start of channel 0
        wr(8'h20, 32'h1);
        check("start_pulse", {29'd0, enable}, 32'h1);
        check("ack_one_cycle", {31'd0, wb_ack_o}, 32'd0);
        busy[0] = 1'b1;
        @(posedge clk); #1;
        check("start_pulse_end", {29'd0, enable}, 32'h0);
        rd(8'h20, 32'h1, "ch0_ctrl_busy");

        // Completion of channel 0
        busy[0] = 1'b0;
        @(posedge clk); #1;
        check("no_restart", {29'd0, enable}, 32'h0);
        check("irq_masked", {31'd0, irq}, 32'd0);
        rd(8'h00, 32'h1, "status_ch0");
        rd(8'h34, 32'h1, "done_ch0");
        wr(8'h04, 32'h1);
        check("irq_unmasked", {31'd0, irq}, 32'd1);
        wr(8'h00, 32'h1);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        rd(8'h00, 32'h0, "status_cleared");

        // Start while busy is refused
        busy[0] = 1'b1;
        repeat (2) @(posedge clk);
        bus(8'h20, 1'b1, 32'h1, d, a, e);
`ifdef WB_STREAM_CFG_ERR_EN
        check("busy_start_ack", {31'd0, a}, 32'd0);
        check("busy_start_err", {31'd0, e}, 32'd1);
`else
        check("busy_start_ack", {31'd0, a}, 32'd1);
        check("busy_start_err", {31'd0, e}, 32'd0);
`endif
        check("busy_start_nopulse", {29'd0, enable}, 32'h0);
        @(posedge clk); #1;
        check("busy_start_nopulse2", {29'd0, enable}, 32'h0);
        busy[0] = 1'b0;
        repeat (2) @(posedge clk);
        rd(8'h34, 32'h2, "done_ch0_2");
        wr(8'h00, 32'h1);

        // Continuous mode on channel 2
        wr(8'h60, 32'h3);
        check("cont_first_pulse", {29'd0, enable}, 32'h4);
        for (int i = 0; i < 3; i++) begin
            busy[2] = 1'b1;
            repeat (2) @(posedge clk);
            #1;
            busy[2] = 1'b0;
            @(posedge clk); #1;
            check($sformatf("auto_pulse_%0d", i), {29'd0, enable}, 32'h4);
            @(posedge clk); #1;
            check($sformatf("auto_pulse_end_%0d", i), {29'd0, enable}, 32'h0);
        end
        rd(8'h74, 32'h3, "done_ch2_3");
        rd(8'h60, 32'h2, "ch2_ctrl_cont");
        wr(8'h00, 32'h7);
        rd(8'h00, 32'h0, "status_clear_all");

        // W1C in the same cycle as a completion: set wins
        busy[2] = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b1; adr_i = 8'h00; dat_i = 32'h4;
        @(posedge clk); #1;
        check("w1c_ack", {31'd0, wb_ack_o}, 32'd1);
        busy[2] = 1'b0;
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
        check("coinc_restart", {29'd0, enable}, 32'h4);
        rd(8'h00, 32'h4, "w1c_set_wins");
        rd(8'h74, 32'h4, "done_ch2_4");

        // Clearing cont stops restarts
        wr(8'h60, 32'h0);
        check("cont_clear_nopulse", {29'd0, enable}, 32'h0);
        busy[2] = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        busy[2] = 1'b0;
        @(posedge clk); #1;
        check("cont_off_nopulse", {29'd0, enable}, 32'h0);
        rd(8'h74, 32'h5, "done_ch2_5");

        // Unmapped accesses
        bus(8'hE0, 1'b0, 32'h0, d, a, e);
        check("unmapped_data", d, 32'h0);
`ifdef WB_STREAM_CFG_ERR_EN
        check("unmapped_ack", {31'd0, a}, 32'd0);
        check("unmapped_err", {31'd0, e}, 32'd1);
`else
        check("unmapped_ack", {31'd0, a}, 32'd1);
        check("unmapped_err", {31'd0, e}, 32'd0);
`endif
        wr(8'h84, 32'hDEAD_BEEF);
        rd(8'h84, 32'h0, "bank4_read");
        wr(8'h38, 32'hFFFF_FFFF);
        rd(8'h38, 32'h0, "reg6_read");
        rd(8'h24, 32'h0, "ch0_start_untouched");
        check("rty", {31'd0, wb_rty_o}, 32'd0);

        // Reset in the commit cycle drops the pending pulse
        @(negedge clk);
        cyc = 1'b1; stb = 1'b1; we_i = 1'b1; adr_i = 8'h20; dat_i = 32'h1;
        @(posedge clk); #1;
        rst = 1'b1;
        busy[1] = 1'b1;
        @(posedge clk); #1;
        check("rst_drops_pulse", {29'd0, enable}, 32'h0);
        cyc = 1'b0; stb = 1'b0; we_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        rd(8'h44, 32'h0, "rst2_ch1_start");
        rd(8'h04, 32'h0, "rst2_mask");
        rd(8'h74, 32'h0, "rst2_done_ch2");
        rd(8'h00, 32'h0, "rst2_status");
        busy[1] = 1'b0;
        @(posedge clk); #1;
        rd(8'h00, 32'h2, "post_rst_fall_status");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
